// File: rtl/flipflop_pkg.sv
// Shared definitions for the FlipFlop register-path blocks: state encodings
// and the counter width helper.
package flipflop_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ff_state_e;

  // Bits needed to hold a bit index 0..width-1; never less than one bit.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_shift32_if.sv
// Load/stream bundle between a word producer and the serializer.
interface piso_shift32_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] d;
  logic             load_valid;
  logic             load_ready;
  logic             shift_en;
  logic             sout;
  logic             sout_valid;
  logic             done;

  modport master (
    output d, load_valid, shift_en,
    input  load_ready, sout, sout_valid, done
  );

  modport slave (
    input  d, load_valid, shift_en,
    output load_ready, sout, sout_valid, done
  );
endinterface

// File: rtl/piso_shift32.sv
// Parallel-in/serial-out shifter: takes one word on a valid/ready load and
// streams it a bit per enabled clock, with zero-gap reload on the last bit.
//
//   state    | meaning
//   ST_IDLE  | no word held, ready for a load, sout_valid low
//   ST_SHIFT | presenting bit of the held word; cnt = bits left after this one
module piso_shift32
  import flipflop_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic         clk,
  input logic         reset_n,
  piso_shift32_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  ff_state_e        state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             load_ready_c;
  logic             last_bit;

  assign last_bit = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    load_ready_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        load_ready_c = 1'b1;
        if (bus.load_valid) begin
          state_d = ST_SHIFT;
          shreg_d = bus.d;
          cnt_d   = CNT_MAX;
        end
      end
      ST_SHIFT: begin
        load_ready_c = last_bit && bus.shift_en;
        if (bus.shift_en) begin
          if (load_ready_c && bus.load_valid) begin
            shreg_d = bus.d;
            cnt_d   = CNT_MAX;
          end else begin
            // After the final shift the register is all fill zeros again.
            shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                : {1'b0, shreg_q[WIDTH-1:1]};
            if (last_bit) state_d = ST_IDLE;
            else          cnt_d   = cnt_q - CW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.load_ready = load_ready_c;
  assign bus.sout_valid = (state_q == ST_SHIFT);
  assign bus.sout       = bus.sout_valid &
                          (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
  assign bus.done       = bus.sout_valid && last_bit;

endmodule

// File: tb/tb_piso_shift32.sv
// Directed bench for piso_shift32: an MSB-first and an LSB-first instance
// share one clock and reset.
`timescale 1ns/100ps
module tb_piso_shift32;

  logic clk = 1'b0;
  logic reset_n;
  int   vectors = 0;
  int   miscompares = 0;

  always #7.5 clk = ~clk;

  piso_shift32_if #(.WIDTH(32)) bus_m ();
  piso_shift32_if #(.WIDTH(32)) bus_l ();

  piso_shift32 #(.WIDTH(32), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset_n(reset_n), .bus(bus_m)
  );
  piso_shift32 #(.WIDTH(32), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset_n(reset_n), .bus(bus_l)
  );

  task automatic test_reset();
    reset_n = 1'b0;
    bus_m.d = 32'hFFFFFFFF; bus_m.load_valid = 1'b1; bus_m.shift_en = 1'b1;
    bus_l.d = 32'hFFFFFFFF; bus_l.load_valid = 1'b1; bus_l.shift_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({bus_m.sout, bus_m.sout_valid, bus_m.done, bus_m.load_ready} !== 4'b0001) begin
      miscompares++;
      $display("FAIL reset_msb: got %b expected 0001",
               {bus_m.sout, bus_m.sout_valid, bus_m.done, bus_m.load_ready});
    end
    vectors++;
    if ({bus_l.sout, bus_l.sout_valid, bus_l.done, bus_l.load_ready} !== 4'b0001) begin
      miscompares++;
      $display("FAIL reset_lsb: got %b expected 0001",
               {bus_l.sout, bus_l.sout_valid, bus_l.done, bus_l.load_ready});
    end
    bus_m.load_valid = 1'b0;
    bus_l.load_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus_m.sout_valid !== 1'b0 || bus_l.sout_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_no_accept: got m=%b l=%b expected 0 0",
               bus_m.sout_valid, bus_l.sout_valid);
    end
  endtask

  task automatic test_msb_first();
    logic [31:0] w = 32'hABCDEF32;
    bus_m.d = w; bus_m.load_valid = 1'b1; bus_m.shift_en = 1'b1;
    @(negedge clk);
    bus_m.load_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      vectors++;
      if (bus_m.sout !== w[31-i] || bus_m.sout_valid !== 1'b1 || bus_m.done !== (i == 31)) begin
        miscompares++;
        $display("FAIL msb_bit%0d: got sout=%b v=%b done=%b expected sout=%b v=1 done=%b",
                 i, bus_m.sout, bus_m.sout_valid, bus_m.done, w[31-i], (i == 31));
      end
      @(negedge clk);
    end
    vectors++;
    if (bus_m.sout_valid !== 1'b0 || bus_m.load_ready !== 1'b1 || bus_m.done !== 1'b0) begin
      miscompares++;
      $display("FAIL msb_idle_after: got v=%b rdy=%b done=%b expected 0 1 0",
               bus_m.sout_valid, bus_m.load_ready, bus_m.done);
    end
  endtask

  task automatic test_lsb_first();
    bus_l.d = 32'h00000001; bus_l.load_valid = 1'b1; bus_l.shift_en = 1'b1;
    @(negedge clk);
    bus_l.load_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      vectors++;
      if (bus_l.sout !== (i == 0) || bus_l.sout_valid !== 1'b1 || bus_l.done !== (i == 31)) begin
        miscompares++;
        $display("FAIL lsb_bit%0d: got sout=%b v=%b done=%b expected sout=%b v=1 done=%b",
                 i, bus_l.sout, bus_l.sout_valid, bus_l.done, (i == 0), (i == 31));
      end
      @(negedge clk);
    end
    vectors++;
    if (bus_l.sout_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL lsb_idle_after: got v=%b expected 0", bus_l.sout_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w0 = 32'h12345678;
    logic [31:0] w1 = 32'h9487D3C1;
    logic [31:0] w;
    int done_cnt = 0;
    bus_m.d = w0; bus_m.load_valid = 1'b1; bus_m.shift_en = 1'b1;
    @(negedge clk);
    bus_m.load_valid = 1'b0;
    for (int i = 0; i < 64; i++) begin
      w = (i < 32) ? w0 : w1;
      if (bus_m.done === 1'b1) done_cnt++;
      vectors++;
      if (bus_m.sout !== w[31-(i%32)] || bus_m.sout_valid !== 1'b1 || bus_m.done !== ((i % 32) == 31)) begin
        miscompares++;
        $display("FAIL b2b_bit%0d: got sout=%b v=%b done=%b expected sout=%b v=1 done=%b",
                 i, bus_m.sout, bus_m.sout_valid, bus_m.done, w[31-(i%32)], ((i % 32) == 31));
      end
      if (i == 31) begin
        bus_m.d = w1; bus_m.load_valid = 1'b1;
        #1;
        vectors++;
        if (bus_m.load_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_ready_last: got %b expected 1", bus_m.load_ready);
        end
      end else begin
        bus_m.load_valid = 1'b0;
      end
      @(negedge clk);
    end
    vectors++;
    if (done_cnt != 2 || bus_m.sout_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_done_count: got %0d v=%b expected 2 v=0", done_cnt, bus_m.sout_valid);
    end
  endtask

  task automatic test_stall();
    logic [31:0] w = 32'h18EE0001;
    int k = 0;
    int stalls = 0;
    bit last_stalled = 1'b0;
    bus_m.d = w; bus_m.load_valid = 1'b1; bus_m.shift_en = 1'b1;
    @(negedge clk);
    bus_m.load_valid = 1'b0;
    // 32 bits + 3 stalls at bit 5 + 1 stall on the last bit
    for (int c = 0; c < 36; c++) begin
      vectors++;
      if (bus_m.sout !== w[31-k] || bus_m.sout_valid !== 1'b1 || bus_m.done !== (k == 31)) begin
        miscompares++;
        $display("FAIL stall_cyc%0d: got sout=%b v=%b done=%b expected sout=%b v=1 done=%b",
                 c, bus_m.sout, bus_m.sout_valid, bus_m.done, w[31-k], (k == 31));
      end
      if (k == 5 && stalls < 3) begin
        bus_m.shift_en = 1'b0;
        stalls++;
      end else if (k == 31 && !last_stalled) begin
        bus_m.shift_en = 1'b0;
        bus_m.load_valid = 1'b1;
        bus_m.d = 32'hFFFF0000;
        last_stalled = 1'b1;
        #1;
        vectors++;
        if (bus_m.load_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL stall_last_ready: got %b expected 0", bus_m.load_ready);
        end
      end else begin
        bus_m.shift_en = 1'b1;
        bus_m.load_valid = 1'b0;
        k++;
      end
      @(negedge clk);
    end
    vectors++;
    if (bus_m.sout_valid !== 1'b0 || k != 32) begin
      miscompares++;
      $display("FAIL stall_end: got v=%b bits=%0d expected v=0 bits=32", bus_m.sout_valid, k);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [31:0] w = 32'hA5A5F00F;
    logic [31:0] w2 = 32'hC0000001;
    bus_m.d = w; bus_m.load_valid = 1'b1; bus_m.shift_en = 1'b1;
    @(negedge clk);
    bus_m.load_valid = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      vectors++;
      if (bus_m.sout !== w[31-i] || bus_m.sout_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL rmid_bit%0d: got sout=%b v=%b expected sout=%b v=1",
                 i, bus_m.sout, bus_m.sout_valid, w[31-i]);
      end
      if (i == 10) reset_n = 1'b0;
      @(negedge clk);
    end
    reset_n = 1'b1;
    vectors++;
    if ({bus_m.sout, bus_m.sout_valid, bus_m.done, bus_m.load_ready} !== 4'b0001) begin
      miscompares++;
      $display("FAIL rmid_after_reset: got %b expected 0001",
               {bus_m.sout, bus_m.sout_valid, bus_m.done, bus_m.load_ready});
    end
    @(negedge clk);
    vectors++;
    if (bus_m.sout_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_word_dropped: got v=%b expected 0", bus_m.sout_valid);
    end
    bus_m.d = w2; bus_m.load_valid = 1'b1;
    @(negedge clk);
    bus_m.load_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (bus_m.sout !== w2[31-i] || bus_m.sout_valid !== 1'b1 || bus_m.done !== 1'b0) begin
        miscompares++;
        $display("FAIL rmid_reload_bit%0d: got sout=%b v=%b done=%b expected sout=%b v=1 done=0",
                 i, bus_m.sout, bus_m.sout_valid, bus_m.done, w2[31-i]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_stall();
    test_reset_mid_word();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
